// File: rtl/seq_detect_1011_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_1011_if
// Description : Interface bundle for the 1011 serial pattern detector.
//               master drives the serial stream and the count clear; slave
//               (the detector) returns the match pulse, count and state.
//   din_valid  master->slave  1      din is sampled only when high
//   din        master->slave  1      serial data bit
//   clear      master->slave  1      synchronous clear of count
//   match      slave->master  1      one-cycle pulse per detected 1011
//   count      slave->master  CNT_W  saturating match count
//   state      slave->master  3      current FSM state code (debug)
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_detect_1011_if #(
    parameter int CNT_W = 8
);
    logic             din_valid;
    logic             din;
    logic             clear;
    logic             match;
    logic [CNT_W-1:0] count;
    logic [2:0]       state;

    modport master (
        output din_valid,
        output din,
        output clear,
        input  match,
        input  count,
        input  state
    );

    modport slave (
        input  din_valid,
        input  din,
        input  clear,
        output match,
        output count,
        output state
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_1011.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_1011
// Description : Serial detector for the bit pattern 1011, overlaps included.
//               Emits a registered one-cycle match pulse and keeps a
//               saturating match counter that can be cleared independently
//               of the FSM.
//   clk    in   1   system clock, rising edge
//   reset  in   1   synchronous active-high reset, highest priority
//   bus    slave modport of seq_detect_1011_if
//          (din_valid, din, clear in; match, count, state out)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_1011 #(
    parameter int CNT_W = 8
) (
    input  wire logic            clk,
    input  wire logic            reset,
    seq_detect_1011_if.slave     bus
);

    typedef enum logic [2:0] {
        S0 = 3'd0,  // no prefix
        S1 = 3'd1,  // "1"
        S2 = 3'd2,  // "10"
        S3 = 3'd3,  // "101"
        S4 = 3'd4   // "1011" seen
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic             r_match;
    logic [CNT_W-1:0] r_count;

    state_t           w_next;
    logic             w_match_evt;

    // Next state. Illegal codes fall to S0 on the next edge regardless of
    // din_valid; legal states hold during bubbles.
    always_comb begin
        w_next = S0;
        case (r_state)
            S0:      w_next = bus.din ? S1 : S0;
            S1:      w_next = bus.din ? S1 : S2;
            S2:      w_next = bus.din ? S3 : S0;
            S3:      w_next = bus.din ? S4 : S2;
            S4:      w_next = bus.din ? S1 : S2;  // keep overlapping suffix
            default: w_next = S0;
        endcase
        if (!bus.din_valid && (r_state <= S4)) begin
            w_next = r_state;
        end
    end

    assign w_match_evt = bus.din_valid && (w_next == S4);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S0;
            r_match <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            r_match <= w_match_evt;
            // clear beats a coincident match; the match pulse is unaffected
            if (bus.clear) begin
                r_count <= '0;
            end else if (w_match_evt && (r_count != c_CNT_MAX)) begin
                r_count <= r_count + c_CNT_ONE;
            end
        end
    end

    assign bus.state = r_state;
    assign bus.match = r_match;
    assign bus.count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_1011.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_1011
// Description : Self-checking bench for seq_detect_1011 (CNT_W=2). A model
//               keeps the recent valid-bit history and derives the expected
//               state as the longest history suffix that is a prefix of 1011.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_1011;

    localparam int CNT_W   = 2;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk;
    logic reset;

    seq_detect_1011_if #(.CNT_W(CNT_W)) bus ();

    seq_detect_1011 #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    bit hist[$];
    int exp_state = 0;
    int exp_match = 0;
    int exp_count = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, obs, exp_v);
        end
    endtask

    // Longest suffix of the valid-bit history that is a prefix of 1011.
    function automatic int suffix_len();
        bit pat[4];
        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
        for (int k = 4; k >= 1; k--) begin
            if (hist.size() >= k) begin
                bit ok;
                ok = 1'b1;
                for (int i = 0; i < k; i++)
                    if (hist[hist.size() - k + i] != pat[i]) ok = 1'b0;
                if (ok) return k;
            end
        end
        return 0;
    endfunction

    task automatic step(input logic v, input logic d, input logic c, input logic r);
        bit ev;
        @(negedge clk);
        bus.din_valid = v;
        bus.din       = d;
        bus.clear     = c;
        reset         = r;
        @(posedge clk);
        if (r) begin
            hist.delete();
            exp_state = 0;
            exp_match = 0;
            exp_count = 0;
        end else begin
            ev = 1'b0;
            if (v) begin
                hist.push_back(d);
                if (hist.size() > 4) void'(hist.pop_front());
                exp_state = suffix_len();
                ev = (exp_state == 4);
            end
            exp_match = ev;
            if (c)       exp_count = 0;
            else if (ev) exp_count = (exp_count < CNT_MAX) ? exp_count + 1 : CNT_MAX;
        end
        #1;
        chk("state", 32'(bus.state), exp_state);
        chk("match", 32'(bus.match), exp_match);
        chk("count", 32'(bus.count), exp_count);
    endtask

    task automatic do_reset();
        step(1'($urandom), 1'($urandom), 1'b0, 1'b1);
        step(1'($urandom), 1'($urandom), 1'b0, 1'b1);
    endtask

    task automatic send(input logic d, input logic c);
        step(1'b1, d, c, 1'b0);
    endtask

    int matches_seen;

    initial begin
        bus.din_valid = 1'b0;
        bus.din       = 1'b0;
        bus.clear     = 1'b0;
        reset         = 1'b1;

        // reset held two cycles with random data, then first idle cycle
        do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_state", 32'(bus.state), 0);
        chk("rst_count", 32'(bus.count), 0);

        // overlap: 1011011
        send(1, 0); send(0, 0); send(1, 0); send(1, 0);
        chk("ovl_m1", 32'(bus.match), 1);
        chk("ovl_s1", 32'(bus.state), 4);
        send(0, 0); send(1, 0); send(1, 0);
        chk("ovl_m2", 32'(bus.match), 1);
        chk("ovl_s2", 32'(bus.state), 4);
        chk("ovl_cnt", 32'(bus.count), 2);

        // bubbles: 1 x 0 x 1 x 1
        do_reset();
        matches_seen = 0;
        step(1, 1, 0, 0);
        step(0, 0, 0, 0); chk("bub_m0", 32'(bus.match), 0);
        step(1, 0, 0, 0);
        step(0, 1, 0, 0); chk("bub_m1", 32'(bus.match), 0);
        step(1, 1, 0, 0);
        step(0, 1, 0, 0); chk("bub_m2", 32'(bus.match), 0);
        step(1, 1, 0, 0);
        chk("bub_mlast", 32'(bus.match), 1);
        chk("bub_cnt", 32'(bus.count), 1);

        // near miss: 101011 -> states 1,2,3,2,3,4
        do_reset();
        send(1, 0); chk("nm_s1", 32'(bus.state), 1);
        send(0, 0); chk("nm_s2", 32'(bus.state), 2);
        send(1, 0); chk("nm_s3", 32'(bus.state), 3);
        send(0, 0); chk("nm_s4", 32'(bus.state), 2);
        send(1, 0); chk("nm_s5", 32'(bus.state), 3);
        chk("nm_nomatch", 32'(bus.match), 0);
        send(1, 0); chk("nm_s6", 32'(bus.state), 4);
        chk("nm_match", 32'(bus.match), 1);

        // saturation: five matches -> 1,2,3,3,3
        do_reset();
        send(1, 0); send(0, 0); send(1, 0); send(1, 0);
        chk("sat_c1", 32'(bus.count), 1);
        for (int i = 2; i <= 5; i++) begin
            send(0, 0); send(1, 0); send(1, 0);
            chk("sat_cn", 32'(bus.count), (i < CNT_MAX) ? i : CNT_MAX);
        end
        // clear coincident with a match event
        send(0, 0); send(1, 0); send(1, 1);
        chk("clr_cnt", 32'(bus.count), 0);
        chk("clr_match", 32'(bus.match), 1);
        send(0, 0); send(1, 0); send(1, 0);
        chk("clr_next", 32'(bus.count), 1);

        // reset mid-pattern
        send(1, 0); send(0, 0); send(1, 0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        send(1, 0);
        chk("mid_state", 32'(bus.state), 1);
        chk("mid_match", 32'(bus.match), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0),
                 1'($urandom),
                 ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 150) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
